// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART tx byte port between
// NUM_REQ producers; ownership lasts until a terminator, a full burst or an idle timeout.
module uart_tx_arbiter #(
    parameter int          NUM_REQ      = 2,
    parameter int          MAX_BURST    = 64,
    parameter int          IDLE_TIMEOUT = 256,
    parameter logic [7:0]  TERM_CHAR    = 8'h0A
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_wvalid_i,
    output logic [NUM_REQ-1:0]     req_wready_o,
    input  logic [8*NUM_REQ-1:0]   req_wdata_i,
    output logic                   wvalid_o,
    input  logic                   wready_i,
    output logic [7:0]             wdata_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam int IC_W  = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] pick;
    logic [BC_W-1:0]  byte_cnt;
    logic [IC_W-1:0]  idle_cnt;
    logic             own_vld;
    logic [7:0]       own_data;
    logic             xfer;
    logic             release_now;

    // First requester found searching upward from ptr+1, wrapping modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   last);
        int   idx;
        logic found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                rr_pick = PTR_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        own_vld     = req_wvalid_i[owner];
        own_data    = req_wdata_i[8*int'(owner) +: 8];
        xfer        = own_vld && wready_i;
        pick        = rr_pick(req_wvalid_i, ptr);
        release_now = (state == OWN) &&
                      ((xfer && (own_data == TERM_CHAR || byte_cnt == BC_W'(MAX_BURST - 1))) ||
                       (!own_vld && idle_cnt == IC_W'(IDLE_TIMEOUT - 1)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            grant_o  <= '0;
            busy_o   <= 1'b0;
            owner    <= '0;
            ptr      <= PTR_W'(NUM_REQ - 1);
            byte_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt == OWN);
            if (state == IDLE) begin
                if (state_nxt == OWN) begin
                    owner   <= pick;
                    grant_o <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                end
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (release_now) begin
                grant_o <= '0;
                ptr     <= owner;
            end else begin
                if (xfer) byte_cnt <= byte_cnt + BC_W'(1);
                idle_cnt <= own_vld ? '0 : idle_cnt + IC_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_wvalid_i) state_nxt = OWN;
            OWN:     if (release_now)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pass-through is blanked during reset so no byte can slip out in the reset cycle.
    always_comb begin
        wvalid_o     = 1'b0;
        wdata_o      = 8'h00;
        req_wready_o = '0;
        if (state == OWN && !rst_i) begin
            wvalid_o            = own_vld;
            wdata_o             = own_data;
            req_wready_o[owner] = wready_i;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: randomized producers driven from byte queues, checked
// every cycle against an integer-level ownership model plus directed scenario checks.
module tb_uart_tx_arbiter;

    localparam int         N    = 2;
    localparam int         MAXB = 64;
    localparam int         ITO  = 256;
    localparam logic [7:0] TERM = 8'h0A;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_wvalid_i;
    logic [N-1:0]   req_wready_o;
    logic [8*N-1:0] req_wdata_i;
    logic           wvalid_o;
    logic           wready_i;
    logic [7:0]     wdata_o;
    logic [N-1:0]   grant_o;
    logic           busy_o;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB), .IDLE_TIMEOUT(ITO), .TERM_CHAR(TERM)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_wvalid_i(req_wvalid_i), .req_wready_o(req_wready_o),
        .req_wdata_i(req_wdata_i), .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    logic [7:0] txq [N][$];
    logic       cur_vld [N];
    logic [7:0] cur_dat [N];
    int own = -1, ptr = N - 1, nbytes = 0, nidle = 0;
    int n_checks = 0, n_err = 0, cyc = 0;
    int pvld = 100, prdy = 100;
    logic rst_req = 1'b1;
    bit mon_en = 1'b0;
    int src_log[$];
    int cyc_log[$];
    logic [7:0] byte_log[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        src_log.delete();
        cyc_log.delete();
        byte_log.delete();
    endtask

    task automatic push_msg(input int r, input string s);
        for (int i = 0; i < s.len(); i++) txq[r].push_back(s[i]);
    endtask

    function automatic logic [7:0] rand_body();
        logic [7:0] b;
        b = 8'($urandom_range(255));
        if (b == TERM) b = 8'h55;
        return b;
    endfunction

    task automatic step();
        logic [N-1:0] eg, er;
        logic         ev, moved;
        logic [7:0]   ed, b;
        int           c, src;
        @(negedge clk_i);
        rst_i    = rst_req;
        wready_i = (int'($urandom_range(99)) < prdy);
        for (int i = 0; i < N; i++) begin
            cur_vld[i] = (txq[i].size() > 0) && (int'($urandom_range(99)) < pvld);
            cur_dat[i] = (txq[i].size() > 0) ? txq[i][0] : 8'($urandom_range(255));
            req_wvalid_i[i]       = cur_vld[i];
            req_wdata_i[8*i +: 8] = cur_dat[i];
        end
        #2;
        eg = '0; er = '0; ev = 1'b0; ed = 8'h00;
        if (own >= 0) eg[own] = 1'b1;
        if (!rst_i && own >= 0) begin
            ev      = cur_vld[own];
            ed      = cur_dat[own];
            er[own] = wready_i;
        end
        if (mon_en) begin
            chk("grant",   32'(grant_o),      32'(eg));
            chk("busy",    32'(busy_o),       32'(own >= 0));
            chk("wvalid",  32'(wvalid_o),     32'(ev));
            chk("wdata",   32'(wdata_o),      32'(ed));
            chk("wready",  32'(req_wready_o), 32'(er));
            if (!rst_i && wvalid_o && wready_i) begin
                src = -1;
                for (int i = 0; i < N; i++) if (grant_o[i]) src = i;
                src_log.push_back(src);
                byte_log.push_back(wdata_o);
                cyc_log.push_back(cyc);
            end
        end
        if (rst_i) begin
            own = -1; ptr = N - 1; nbytes = 0; nidle = 0;
        end else if (own < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (ptr + k) % N;
                if (own < 0 && cur_vld[c]) own = c;
            end
            nbytes = 0; nidle = 0;
        end else begin
            moved = cur_vld[own] && wready_i;
            b     = cur_dat[own];
            if (moved) begin
                void'(txq[own].pop_front());
                nbytes++;
            end
            nidle = cur_vld[own] ? 0 : nidle + 1;
            if ((moved && (b == TERM || nbytes == MAXB)) || nidle == ITO) begin
                ptr = own;
                own = -1;
            end
        end
        cyc++;
    endtask

    task automatic drain(input string tag, input int maxc);
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < maxc) begin
            step();
            n++;
            pending = (own >= 0);
            for (int i = 0; i < N; i++) if (txq[i].size() > 0) pending = 1'b1;
        end
        chk(tag, 32'(pending), 32'(0));
    endtask

    int         c0, nruns;
    int         run_src[$], run_len[$];
    logic [7:0] b;

    initial begin
        rst_i = 1'b1; wready_i = 1'b0; req_wvalid_i = '0; req_wdata_i = '0;
        step();
        mon_en = 1'b1;
        step(); step();
        rst_req = 1'b0;
        step(); step();
        chk("rst_grant", 32'(grant_o), 32'(0));
        chk("rst_busy",  32'(busy_o),  32'(0));

        // "AB\n" from requester 0 with the uart always ready
        clear_logs();
        push_msg(0, "AB\n");
        c0 = cyc;
        drain("ab_drain", 20);
        chk("ab_len", 32'(byte_log.size()), 32'(3));
        if (byte_log.size() >= 3) begin
            chk("ab_b0",  32'(byte_log[0]), 32'h41);
            chk("ab_b1",  32'(byte_log[1]), 32'h42);
            chk("ab_b2",  32'(byte_log[2]), 32'h0A);
            chk("ab_lat", 32'(cyc_log[0] - c0), 32'(1));
            chk("ab_seq", 32'(cyc_log[2] - cyc_log[0]), 32'(2));
        end

        // Both requesters streaming short messages: whole messages alternate
        clear_logs();
        for (int m = 0; m < 3; m++) begin
            push_msg(0, "x\n");
            push_msg(1, "x\n");
        end
        drain("ilv_drain", 60);
        chk("ilv_len", 32'(src_log.size()), 32'(12));
        for (int k = 0; k + 1 < src_log.size(); k += 2) begin
            chk("ilv_pair", 32'(src_log[k + 1]), 32'(src_log[k]));
            if (k >= 2) chk("ilv_alt", 32'(src_log[k]), 32'(1 - src_log[k - 2]));
        end

        // 100 unterminated bytes from requester 1 with requester 0 pending
        clear_logs();
        for (int i = 0; i < 100; i++) txq[1].push_back(rand_body());
        push_msg(0, "z\n");
        drain("burst_drain", 700);
        run_src.delete(); run_len.delete();
        for (int i = 0; i < src_log.size(); i++) begin
            if (run_src.size() == 0 || run_src[$] != src_log[i]) begin
                run_src.push_back(src_log[i]);
                run_len.push_back(1);
            end else begin
                run_len[run_len.size() - 1] = run_len[$] + 1;
            end
        end
        nruns = run_src.size();
        chk("burst_runs", 32'(nruns), 32'(3));
        if (nruns == 3) begin
            chk("burst_len0", 32'(run_len[0]), 32'(64));
            chk("burst_src0", 32'(run_src[0]), 32'(1));
            chk("burst_len1", 32'(run_len[1]), 32'(2));
            chk("burst_len2", 32'(run_len[2]), 32'(36));
            chk("burst_src2", 32'(run_src[2]), 32'(1));
        end

        // Owner sends one byte then goes quiet; requester 1 waits for the timeout
        clear_logs();
        txq[0].push_back(8'h51);
        push_msg(1, "r\n");
        drain("to_drain", 600);
        chk("to_len", 32'(src_log.size()), 32'(3));
        if (src_log.size() >= 2) begin
            chk("to_src0", 32'(src_log[0]), 32'(0));
            chk("to_src1", 32'(src_log[1]), 32'(1));
            chk("to_gap",  32'(cyc_log[1] - cyc_log[0]), 32'(ITO + 2));
        end

        // Long stall with valid held high must not time out
        clear_logs();
        push_msg(0, "S\n");
        prdy = 0;
        repeat (500) step();
        chk("stall_grant",  32'(grant_o),      32'(1));
        chk("stall_wvalid", 32'(wvalid_o),     32'(1));
        chk("stall_rdy",    32'(req_wready_o), 32'(0));
        prdy = 100;
        drain("stall_drain", 20);
        chk("stall_len", 32'(byte_log.size()), 32'(2));

        // Reset in the middle of a requester-1 message
        clear_logs();
        for (int i = 0; i < 10; i++) txq[1].push_back(rand_body());
        push_msg(0, "a\n");
        repeat (4) step();
        chk("prst_owner", 32'(grant_o), 32'(2));
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("prst_grant",  32'(grant_o),  32'(0));
        chk("prst_busy",   32'(busy_o),   32'(0));
        chk("prst_wvalid", 32'(wvalid_o), 32'(0));
        step();
        chk("prst_first",  32'(grant_o),  32'(1));
        drain("prst_drain", 800);

        // Randomized traffic, stalls and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                pvld = int'($urandom_range(100, 30));
                prdy = int'($urandom_range(100, 20));
            end
            for (int i = 0; i < N; i++) begin
                if (txq[i].size() == 0 && $urandom_range(99) < 10) begin
                    c0 = ($urandom_range(9) == 0) ? int'($urandom_range(90, 65))
                                                  : int'($urandom_range(12, 1));
                    for (int j = 0; j < c0; j++) txq[i].push_back(rand_body());
                    if ($urandom_range(3) != 0) txq[i].push_back(TERM);
                end
            end
            rst_req = ($urandom_range(999) == 0);
            step();
        end
        rst_req = 1'b0; pvld = 100; prdy = 100;
        drain("rand_drain", 2000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
